// File: rtl/i2c_target_pkg.sv
// Shared types and widths for the I2C target endpoint.
package i2c_pkg;
   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WRITE,
      WRITE_ACK,
      READ,
      READ_ACK,
      IGNORE
   } i2c_state_t;
endpackage

// File: rtl/i2c_target_if.sv
// Bus pins and byte-wide user side of the I2C target, plus the FSM state for observation.
interface i2c_target_if;
   import i2c_pkg::*;

   logic                  scl;
   logic                  sda_in;
   logic                  sda_oe;
   logic [I2C_BYTE_W-1:0] rx_data;
   logic                  rx_valid;
   logic                  tx_load;
   logic [I2C_BYTE_W-1:0] tx_data;
   logic                  busy;
   i2c_state_t            state;

   // rx_valid and tx_load are single-cycle strobes with no back-pressure; the user
   // side must take rx_data on rx_valid and hold tx_data stable whenever tx_load can fire.
   modport slave  (input  scl, sda_in, tx_data,
                   output sda_oe, rx_data, rx_valid, tx_load, busy, state);
   modport master (output scl, sda_in, tx_data,
                   input  sda_oe, rx_data, rx_valid, tx_load, busy, state);
endinterface

// File: rtl/i2c_target_line_sync.sv
// Two-flop synchronizer plus registered edge detector for one raw I2C pad line.
module i2c_line_sync (
   input  logic ref_clk,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);
   logic meta, sync, prev;

   // Flops reset high to match an idle bus, so release from reset creates no edge.
   always_ff @(posedge ref_clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         meta <= raw;
         sync <= meta;
         prev <= sync;
         rise <= sync & ~prev;
         fall <= ~sync & prev;
      end
   end

   assign level = prev;
endmodule

// File: rtl/i2c_target.sv
// I2C target with fixed 7-bit address, byte-wide RX/TX strobes and no clock stretching.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50
) (
   input logic          ref_clk,
   input logic          reset_n,
   i2c_target_if.slave  bus
);
   logic scl_level, scl_rise, scl_fall;
   logic sda_level, sda_rise, sda_fall;

   i2c_line_sync u_scl (.ref_clk(ref_clk), .reset_n(reset_n), .raw(bus.scl),
                        .level(scl_level), .rise(scl_rise), .fall(scl_fall));
   i2c_line_sync u_sda (.ref_clk(ref_clk), .reset_n(reset_n), .raw(bus.sda_in),
                        .level(sda_level), .rise(sda_rise), .fall(sda_fall));

   i2c_state_t            state;
   logic [2:0]            bit_cnt;
   logic [I2C_BYTE_W-1:0] shift;
   logic [I2C_BYTE_W-1:0] shift_nxt;
   logic                  ack_on;
   logic                  rw;
   logic                  sda_oe;
   logic [I2C_BYTE_W-1:0] rx_data;
   logic                  rx_valid;
   logic                  tx_load;
   logic                  busy;
   logic                  start_det;
   logic                  stop_det;

   assign start_det = sda_fall & scl_level;
   assign stop_det  = sda_rise & scl_level;
   assign shift_nxt = {shift[I2C_BYTE_W-2:0], sda_level};

   always_ff @(posedge ref_clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         bit_cnt  <= 3'd0;
         shift    <= '0;
         ack_on   <= 1'b0;
         rw       <= 1'b0;
         sda_oe   <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         tx_load  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         tx_load  <= 1'b0;
         if (start_det) begin
            state   <= ADDR;
            bit_cnt <= 3'd0;
            sda_oe  <= 1'b0;
            ack_on  <= 1'b0;
         end else if (stop_det) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
            ack_on <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               ADDR: if (scl_rise) begin
                  shift   <= shift_nxt;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (shift_nxt[I2C_BYTE_W-1:1] == TARGET_ADDR) begin
                        state <= ADDR_ACK;
                        busy  <= 1'b1;
                        rw    <= shift_nxt[0];
                     end else begin
                        state <= IGNORE;
                        busy  <= 1'b0;
                     end
                  end
               end
               // First fall pulls SDA for the ACK slot, the second ends the slot.
               ADDR_ACK, WRITE_ACK: if (scl_fall) begin
                  if (!ack_on) begin
                     sda_oe <= 1'b1;
                     ack_on <= 1'b1;
                  end else begin
                     ack_on <= 1'b0;
                     if (state == ADDR_ACK && rw) begin
                        state   <= READ;
                        tx_load <= 1'b1;
                        shift   <= bus.tx_data;
                        sda_oe  <= ~bus.tx_data[I2C_BYTE_W-1];
                        bit_cnt <= 3'd0;
                     end else begin
                        state  <= WRITE;
                        sda_oe <= 1'b0;
                     end
                  end
               end
               WRITE: if (scl_rise) begin
                  shift   <= shift_nxt;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rx_data  <= shift_nxt;
                     rx_valid <= 1'b1;
                     state    <= WRITE_ACK;
                  end
               end
               READ: if (scl_fall) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     sda_oe <= 1'b0;
                     state  <= READ_ACK;
                  end else begin
                     sda_oe <= ~shift[I2C_BYTE_W-2];
                     shift  <= {shift[I2C_BYTE_W-2:0], 1'b0};
                  end
               end
               READ_ACK: if (scl_rise) begin
                  if (sda_level) begin
                     state <= IGNORE;
                     busy  <= 1'b0;
                  end else begin
                     ack_on <= 1'b1;
                  end
               end else if (scl_fall && ack_on) begin
                  ack_on  <= 1'b0;
                  state   <= READ;
                  tx_load <= 1'b1;
                  shift   <= bus.tx_data;
                  sda_oe  <= ~bus.tx_data[I2C_BYTE_W-1];
                  bit_cnt <= 3'd0;
               end
               IGNORE: begin
                  sda_oe <= 1'b0;
                  busy   <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.sda_oe   = sda_oe;
   assign bus.rx_data  = rx_data;
   assign bus.rx_valid = rx_valid;
   assign bus.tx_load  = tx_load;
   assign bus.busy     = busy;
   assign bus.state    = state;
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-level I2C controller model over an open-drain SDA line.
module tb_i2c_target;
   import i2c_pkg::*;

   localparam int Q = 8;

   logic       ref_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       m_scl   = 1'b1;
   logic       m_sda   = 1'b1;
   logic [7:0] tx_reg  = 8'h00;
   logic       sda_line;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int last_rise = 0;
   int r8 = 0;
   int rx_cyc = 0;
   int contention = 0;
   logic oe_seen = 1'b0;
   logic busy_seen = 1'b0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   logic       tx_oe_q[$];

   i2c_target_if bus ();

   i2c_target #(.TARGET_ADDR(7'h50)) dut (
      .ref_clk(ref_clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   assign sda_line    = m_sda & ~bus.sda_oe;
   assign bus.scl     = m_scl;
   assign bus.sda_in  = sda_line;
   assign bus.tx_data = tx_reg;

   always #5 ref_clk = ~ref_clk;
   always @(posedge ref_clk) cyc <= cyc + 1;

   always @(negedge ref_clk) begin
      if (bus.rx_valid) begin
         rx_q.push_back(bus.rx_data);
         rx_cyc = cyc;
      end
      if (bus.tx_load) tx_oe_q.push_back(bus.sda_oe);
      if (bus.sda_oe) oe_seen = 1'b1;
      if (bus.busy) busy_seen = 1'b1;
   end

   task automatic bit_xfer(input logic b, output logic s);
      m_sda = b;
      repeat (Q) @(negedge ref_clk);
      m_scl = 1'b1;
      last_rise = cyc;
      repeat (Q) @(negedge ref_clk);
      s = sda_line;
      m_scl = 1'b0;
      repeat (2) @(negedge ref_clk);
   endtask

   task automatic bus_start();
      m_sda = 1'b1;
      repeat (Q) @(negedge ref_clk);
      m_scl = 1'b1;
      repeat (Q) @(negedge ref_clk);
      m_sda = 1'b0;
      repeat (Q) @(negedge ref_clk);
      m_scl = 1'b0;
      repeat (2) @(negedge ref_clk);
   endtask

   task automatic bus_stop();
      m_sda = 1'b0;
      repeat (Q) @(negedge ref_clk);
      m_scl = 1'b1;
      repeat (Q) @(negedge ref_clk);
      m_sda = 1'b1;
      repeat (Q) @(negedge ref_clk);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(d[i], s);
         if (d[i] && !s) contention++;
      end
      r8 = last_rise;
      bit_xfer(1'b1, s);
      ack = ~s;
   endtask

   task automatic recv_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         d[i] = s;
      end
      tx_reg = next_tx;
      bit_xfer(nack, s);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge ref_clk);
      n_total++; if (bus.sda_oe !== 1'b0) $display("FAIL reset_sda_oe got %b exp 0", bus.sda_oe); else n_pass++;
      n_total++; if (bus.rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", bus.rx_data); else n_pass++;
      n_total++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", bus.rx_valid); else n_pass++;
      n_total++; if (bus.tx_load !== 1'b0) $display("FAIL reset_tx_load got %b exp 0", bus.tx_load); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else n_pass++;
      n_total++; if (bus.state !== IDLE) $display("FAIL reset_state got %0d exp %0d", bus.state, IDLE); else n_pass++;
      reset_n = 1'b1;
      repeat (5) @(negedge ref_clk);
   endtask

   task automatic test_write();
      logic ack;
      rx_q.delete();
      exp_q.delete();
      contention = 0;
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hC3);
      bus_start();
      send_byte(8'hA0, ack);
      n_total++; if (ack !== 1'b1) $display("FAIL wr_addr_ack got %b exp 1", ack); else n_pass++;
      n_total++; if (bus.busy !== 1'b1) $display("FAIL wr_busy_mid got %b exp 1", bus.busy); else n_pass++;
      send_byte(8'h3C, ack);
      n_total++; if (ack !== 1'b1) $display("FAIL wr_b1_ack got %b exp 1", ack); else n_pass++;
      n_total++; if (rx_cyc - r8 !== 4) $display("FAIL wr_rx_latency got %0d exp 4", rx_cyc - r8); else n_pass++;
      send_byte(8'hC3, ack);
      n_total++; if (ack !== 1'b1) $display("FAIL wr_b2_ack got %b exp 1", ack); else n_pass++;
      bus_stop();
      n_total++; if (rx_q.size() !== exp_q.size()) $display("FAIL wr_rx_count got %0d exp %0d", rx_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_total++; if (rx_q[i] !== exp_q[i]) $display("FAIL wr_rx_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]); else n_pass++;
      end
      n_total++; if (bus.rx_data !== 8'hC3) $display("FAIL wr_rx_hold got %h exp c3", bus.rx_data); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL wr_busy_stop got %b exp 0", bus.busy); else n_pass++;
      n_total++; if (bus.state !== IDLE) $display("FAIL wr_state_stop got %0d exp %0d", bus.state, IDLE); else n_pass++;
      n_total++; if (contention !== 0) $display("FAIL wr_contention got %0d exp 0", contention); else n_pass++;
   endtask

   task automatic test_read();
      logic ack;
      logic [7:0] d1, d2;
      tx_oe_q.delete();
      tx_reg = 8'h96;
      bus_start();
      send_byte(8'hA1, ack);
      n_total++; if (ack !== 1'b1) $display("FAIL rd_addr_ack got %b exp 1", ack); else n_pass++;
      recv_byte(1'b0, 8'h5A, d1);
      recv_byte(1'b1, 8'h00, d2);
      n_total++; if (d1 !== 8'h96) $display("FAIL rd_byte1 got %h exp 96", d1); else n_pass++;
      n_total++; if (d2 !== 8'h5A) $display("FAIL rd_byte2 got %h exp 5a", d2); else n_pass++;
      repeat (4) @(negedge ref_clk);
      n_total++; if (bus.sda_oe !== 1'b0) $display("FAIL rd_release_nack got %b exp 0", bus.sda_oe); else n_pass++;
      n_total++; if (bus.state !== IGNORE) $display("FAIL rd_state_nack got %0d exp %0d", bus.state, IGNORE); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL rd_busy_nack got %b exp 0", bus.busy); else n_pass++;
      bus_stop();
      n_total++; if (bus.state !== IDLE) $display("FAIL rd_state_stop got %0d exp %0d", bus.state, IDLE); else n_pass++;
      n_total++; if (tx_oe_q.size() !== 2) $display("FAIL rd_tx_load_count got %0d exp 2", tx_oe_q.size()); else n_pass++;
      if (tx_oe_q.size() == 2) begin
         n_total++; if (tx_oe_q[0] !== 1'b0) $display("FAIL rd_load1_oe got %b exp 0", tx_oe_q[0]); else n_pass++;
         n_total++; if (tx_oe_q[1] !== 1'b1) $display("FAIL rd_load2_oe got %b exp 1", tx_oe_q[1]); else n_pass++;
      end
   endtask

   task automatic test_mismatch();
      logic ack;
      rx_q.delete();
      oe_seen = 1'b0;
      busy_seen = 1'b0;
      bus_start();
      send_byte(8'hA2, ack);
      n_total++; if (ack !== 1'b0) $display("FAIL mm_addr_ack got %b exp 0", ack); else n_pass++;
      n_total++; if (bus.state !== IGNORE) $display("FAIL mm_state got %0d exp %0d", bus.state, IGNORE); else n_pass++;
      send_byte(8'hFF, ack);
      bus_stop();
      n_total++; if (oe_seen !== 1'b0) $display("FAIL mm_oe_seen got %b exp 0", oe_seen); else n_pass++;
      n_total++; if (rx_q.size() !== 0) $display("FAIL mm_rx_count got %0d exp 0", rx_q.size()); else n_pass++;
      n_total++; if (busy_seen !== 1'b0) $display("FAIL mm_busy_seen got %b exp 0", busy_seen); else n_pass++;
   endtask

   task automatic test_repeated_start();
      logic ack;
      logic [7:0] d;
      rx_q.delete();
      tx_oe_q.delete();
      contention = 0;
      tx_reg = 8'hA5;
      bus_start();
      send_byte(8'hA0, ack);
      send_byte(8'h11, ack);
      n_total++; if (ack !== 1'b1) $display("FAIL rs_wr_ack got %b exp 1", ack); else n_pass++;
      bus_start();
      send_byte(8'hA1, ack);
      n_total++; if (ack !== 1'b1) $display("FAIL rs_rd_addr_ack got %b exp 1", ack); else n_pass++;
      recv_byte(1'b1, 8'h00, d);
      bus_stop();
      n_total++; if (d !== 8'hA5) $display("FAIL rs_rd_byte got %h exp a5", d); else n_pass++;
      n_total++; if (rx_q.size() !== 1) $display("FAIL rs_rx_count got %0d exp 1", rx_q.size()); else n_pass++;
      if (rx_q.size() > 0) begin
         n_total++; if (rx_q[0] !== 8'h11) $display("FAIL rs_rx_byte got %h exp 11", rx_q[0]); else n_pass++;
      end
      n_total++; if (tx_oe_q.size() !== 1) $display("FAIL rs_tx_load_count got %0d exp 1", tx_oe_q.size()); else n_pass++;
      n_total++; if (contention !== 0) $display("FAIL rs_contention got %0d exp 0", contention); else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      logic ack, s;
      tx_reg = 8'h00;
      bus_start();
      send_byte(8'hA1, ack);
      for (int i = 0; i < 4; i++) bit_xfer(1'b1, s);
      repeat (4) @(negedge ref_clk);
      n_total++; if (bus.sda_oe !== 1'b1) $display("FAIL rm_oe_driving got %b exp 1", bus.sda_oe); else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++; if (bus.sda_oe !== 1'b0) $display("FAIL rm_oe_async got %b exp 0", bus.sda_oe); else n_pass++;
      n_total++; if (bus.rx_data !== 8'h00) $display("FAIL rm_rx_data got %h exp 00", bus.rx_data); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL rm_busy got %b exp 0", bus.busy); else n_pass++;
      n_total++; if (bus.state !== IDLE) $display("FAIL rm_state got %0d exp %0d", bus.state, IDLE); else n_pass++;
      repeat (2) @(negedge ref_clk);
      m_scl = 1'b1;
      m_sda = 1'b1;
      repeat (4) @(negedge ref_clk);
      reset_n = 1'b1;
      repeat (8) @(negedge ref_clk);
      bus_start();
      send_byte(8'hA0, ack);
      n_total++; if (ack !== 1'b1) $display("FAIL rm_after_ack got %b exp 1", ack); else n_pass++;
      bus_stop();
   endtask

   task automatic test_abort();
      logic ack, s;
      rx_q.delete();
      bus_start();
      send_byte(8'hA0, ack);
      bit_xfer(1'b1, s);
      bit_xfer(1'b0, s);
      bit_xfer(1'b1, s);
      bit_xfer(1'b0, s);
      bus_stop();
      n_total++; if (rx_q.size() !== 0) $display("FAIL ab_rx_count got %0d exp 0", rx_q.size()); else n_pass++;
      n_total++; if (bus.state !== IDLE) $display("FAIL ab_state got %0d exp %0d", bus.state, IDLE); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL ab_busy got %b exp 0", bus.busy); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_mismatch();
      test_repeated_start();
      test_reset_mid_read();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) endpoint for the same bus our controller side drives from the divided I2C clock. It oversamples SCL and SDA on the fast reference clock, detects START, repeated START and STOP, and matches a fixed 7-bit address. It accepts write bytes and supplies read bytes through a simple byte-wide user interface. It is a standard-mode/fast-mode target with no clock stretching.

## Interface
- TARGET_ADDR, 7'h50, 7-bit bus address this target responds to.
- REF_CLK  in  1  system clock; must be ≥ 16× SCL frequency.
- RESET_N  in  1  asynchronous, active-low reset.
- SCL  in  1  bus clock, raw from pad. Asynchronous to REF_CLK.
- SDA_IN  in  1  bus data, raw from pad.
- SDA_OE  out  1  1 = pull SDA low. 0 = release. The pad is open-drain, external.
- RX_DATA  out  8  last byte written by the controller. Valid while RX_VALID is high and held afterwards.
- RX_VALID  out  1  one-cycle pulse per received data byte. Not pulsed for the address byte.
- TX_LOAD  out  1  one-cycle pulse. TX_DATA is captured in the same REF_CLK cycle.
- TX_DATA  in  8  byte to send on a read. Must be stable whenever TX_LOAD can pulse.
- BUSY  out  1  high from an address match until STOP, mismatch-ignore, or NACK end.

## Operation
- SCL and SDA each pass through a 2-flop synchronizer, then a 1-flop edge detector. The detector gives scl_rise, scl_fall, sda_rise and sda_fall.
- START: sda_fall while synchronized SCL is high. STOP: sda_rise while SCL is high.
- START and STOP override any state and any same-cycle bit event.
  - START in any state: go to ADDR, clear the bit counter, SDA_OE = 0.
  - STOP in any state: go to IDLE, SDA_OE = 0, BUSY = 0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first on scl_rise (7 address bits plus R/W). After the 8th bit, a match goes to ADDR_ACK. A mismatch goes to IGNORE.
  - ADDR_ACK: assert SDA_OE on the scl_fall after bit 8 and release it on the next scl_fall. Then go to WRITE if R/W=0, or READ if R/W=1.
  - IGNORE: SDA_OE = 0 and BUSY = 0. Leave only on START or STOP.
  - WRITE: shift 8 bits on scl_rise. On the 8th rise, update RX_DATA and pulse RX_VALID. Then go to WRITE_ACK.
  - WRITE_ACK: always ACK, with the same SDA_OE window as ADDR_ACK. Then return to WRITE.
  - READ: on entry (the scl_fall that ends the ACK), pulse TX_LOAD and load the shift register. Drive bit 7 immediately. Present each following bit on each scl_fall; SDA_OE = ~bit. After the 8th bit's scl_fall, release SDA and go to READ_ACK.
  - READ_ACK: sample SDA on scl_rise. 0 (ACK) returns to READ on the next scl_fall. 1 (NACK) goes to IGNORE until STOP or START.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.
- Address 0x00 (general call) is not special. It matches only if TARGET_ADDR = 0.

## Timing
- Reset values: SDA_OE = 0, RX_DATA = 8'h00, RX_VALID = 0, TX_LOAD = 0, BUSY = 0, state IDLE.
- Reset mid-transfer releases SDA immediately, because the reset is asynchronous.
- Detection latency is 3 REF_CLK cycles from a pad edge to the internal event. SDA_OE changes 1 cycle after that event, so 4 REF_CLK from the SCL pad edge.
- RX_VALID asserts 4 REF_CLK after the 8th data-bit SCL rising pad edge.
- TX_LOAD asserts in the same cycle that SDA_OE takes bit 7 of the new byte.
- BUSY rises with the transition into ADDR_ACK. It falls on STOP, or on entry to IGNORE.
- Repeated START during a READ byte abandons the byte. No RX_VALID or TX_LOAD pulse occurs for the partial byte.

## Structure
- Package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE);
  - I2C_ADDR_W = 7;
  - I2C_BYTE_W = 8.
- Sub-module i2c_line_sync, instanced once per line (SCL, SDA). It contains the 2-flop synchronizer and edge detector, with outputs level, rise and fall.
- The FSM, shift register, bit counter and output registers live in i2c_target.

## Test plan
- Write: START, 0xA0 (0x50, W), 0x3C, 0xC3, STOP → ACK on all three bytes. RX_VALID pulses twice, with RX_DATA 0x3C then 0xC3. BUSY falls at STOP.
- Read: START, 0xA1, TX_DATA 0x96 then 0x5A, controller ACKs byte 1 and NACKs byte 2, STOP → SDA carries 0x96 then 0x5A. TX_LOAD pulses exactly twice. SDA is released after the NACK.
- Mismatch: START, 0xA2 (0x51, W), 0xFF, STOP → SDA_OE never asserts. No RX_VALID. BUSY stays 0.
- Repeated START: START, 0xA0, 0x11, Sr, 0xA1, read 1 byte, NACK, STOP → RX_VALID once with 0x11, TX_LOAD once, no bus contention.
- Reset mid-read: RESET_N low while driving bit 3 of 0x00 → SDA_OE = 0 within the same cycle, all outputs at reset values. After release, the next START+0xA0 is ACKed.
- Abort: STOP after 4 bits of a write byte → no RX_VALID, state IDLE, BUSY = 0.
